barrett_reduce_param: RTL and testbench
=======================================

BARRETT_REDUCE_PARAM -- requirements
Module: barrett_reduce_param

Interface
REQ-001 SHALL have parameter K, default 253: modulus width in bits; the modulus satisfies 2^(K-1) <= M < 2^K.
REQ-002 SHALL have parameter M, default ED25519_L from the package: the modulus.
REQ-003 SHALL have parameter MU, default ED25519_MU from the package: floor(4^K / M), K+1 bits.
REQ-004 SHALL have parameter MULT_W, default 256: operand width of the external multiplier.
REQ-005 SHALL have parameter MULT_LAT, default 10: multiplier latency in cycles, >= 1.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_data  in  2K  operand x, x < 2^(2K).
REQ-009 in_valid  in  1  operand offered.
REQ-010 in_ready  out  1  block can accept an operand.
REQ-011 out_data  out  K  result x mod M.
REQ-012 out_valid  out  1  result held on out_data.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 mult_a  out  MULT_W  multiplier operand A; zero when unused.
REQ-015 mult_b  out  MULT_W  multiplier operand B; zero when unused.
REQ-016 mult_p  in  2*MULT_W  product of mult_a and mult_b, valid once the operands have been held for MULT_LAT cycles.

Function
REQ-017 SHALL implement the following states: IDLE, MUL1, MUL2, SUB0, SUB1, SUB2, DONE.
REQ-018 SHALL assert in_ready only in IDLE, and SHALL capture in_data into x_reg on the edge where in_valid and in_ready are both high; the state then becomes MUL1.
REQ-019 SHALL, in MUL1, drive mult_a = x_reg >> (K-1) (K+1 bits) and mult_b = MU for MULT_LAT cycles; on the last MUL1 cycle it SHALL capture q3 = mult_p >> (K+1) and go to MUL2.
REQ-020 SHALL, in MUL2, drive mult_a = q3 and mult_b = M for MULT_LAT cycles; on the last cycle it SHALL capture the low K+1 bits of mult_p and go to SUB0.
REQ-021 SUB0 SHALL register r = (x_reg[K:0] - p[K:0]) mod 2^(K+1).
REQ-022 SUB1 and SUB2 SHALL each register r - M if r >= M, and otherwise r unchanged; the result is always < M.
REQ-023 SHALL hold out_valid high in DONE, with out_data = r[K-1:0] stable until out_valid and out_ready are both high; it then returns to IDLE.
REQ-024 Latency SHALL be exactly 2*MULT_LAT+4 cycles from the accept edge to the first out_valid cycle (24 at defaults).
REQ-025 SHALL NOT accept a new operand in the DONE-to-IDLE transition cycle; throughput is one result per 2*MULT_LAT+5 cycles with no backpressure.
REQ-026 A single shared down-counter SHALL time MUL1 and MUL2, reloaded with MULT_LAT-1 on entry to each state.
REQ-027 SHALL elaborate-fail if K+1 > MULT_W or MULT_LAT < 1.
REQ-028 out_data SHALL be zero whenever out_valid is low.

Reset
REQ-029 rst SHALL force IDLE, counter 0, x_reg/r 0, in_ready 1 (from the next cycle), out_valid 0, out_data 0, mult_a/mult_b 0.
REQ-030 rst mid-operation SHALL abandon the operation with no out_valid pulse; the first operand after reset SHALL produce a correct result.

Configuration
REQ-031 Macro BARRETT_BYPASS_EN: when defined, an accepted x with x < M SHALL go directly to DONE with r = x (latency 1 cycle, multiplier operands stay zero); when undefined, every operand SHALL take the full path of REQ-024.

Structure
REQ-032 Package barrett_pkg SHALL hold ED25519_L, ED25519_MU and the state enumeration constants.
REQ-033 The conditional subtract (r >= M ? r-M : r, K+1 bits) SHALL be sub-module barrett_csub, instanced once and shared by SUB1 and SUB2.

Verification
REQ-034 x=0 -> out_data=0 with out_valid 24 cycles after accept (defaults, no bypass).
REQ-035 x=M+5 -> 5; x=2M-1 -> M-1; x=M*M-1 -> M-1; x=2^506-1 -> golden-model x mod M.
REQ-036 out_ready held low for 7 cycles in DONE -> out_data and out_valid stay stable and in_ready stays 0; release -> IDLE next cycle.
REQ-037 rst pulsed during MUL2 -> no out_valid; mult_a=0 the following cycle; next operand x=M+1 -> 1.
REQ-038 With BARRETT_BYPASS_EN, x=7 -> 7 with latency 1 and mult_a never nonzero; x=M -> full path (24 cycles), result 0.
REQ-039 K=127, M=2^127-1, MULT_LAT=3 -> 1000 random x compared to the golden model, latency 10 each.

Source files
------------

// File: rtl/barrett_pkg.sv
// Shared constants and FSM encoding for the Barrett reduction slice.
// The default modulus is the Ed25519 group order L.
package barrett_pkg;

  localparam int ED25519_K = 253;

  localparam logic [252:0] ED25519_L =
    253'h1000_0000_0000_0000_0000_0000_0000_0000_14de_f9de_a2f7_9cd6_5812_631a_5cf5_d3ed;

  // floor(4^K / L) is folded at elaboration so it cannot drift from L.
  localparam logic [506:0] ED25519_4K = 507'd1 << 506;
  localparam logic [253:0] ED25519_MU = 254'(ED25519_4K / 507'(ED25519_L));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    MUL2 = 3'd2,
    SUB0 = 3'd3,
    SUB1 = 3'd4,
    SUB2 = 3'd5,
    DONE = 3'd6
  } barrett_state_e;

endpackage

// File: rtl/barrett_csub.sv
// Conditional subtract: r >= M ? r - M : r, on K+1 bit values.
// Shared by both correction steps of the reduction.
module barrett_csub #(
  parameter int           K = 253,
  parameter logic [K-1:0] M = '1
) (
  input  logic [K:0] r_i,
  output logic [K:0] r_o
);

  logic [K:0] m_ext;

  assign m_ext = {1'b0, M};
  assign r_o   = (r_i >= m_ext) ? (r_i - m_ext) : r_i;

endmodule

// File: rtl/barrett_reduce_param.sv
// Barrett reduction out = x mod M using a time-shared external multiplier.
// Define BARRETT_BYPASS_EN to let operands already below M go straight to DONE.
module barrett_reduce_param
  import barrett_pkg::*;
#(
  parameter int           K        = 253,
  parameter logic [K-1:0] M        = ED25519_L,
  parameter logic [K:0]   MU       = ED25519_MU,
  parameter int           MULT_W   = 256,
  parameter int           MULT_LAT = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*K-1:0]      in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [K-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MULT_W-1:0]   mult_a,
  output logic [MULT_W-1:0]   mult_b,
  input  logic [2*MULT_W-1:0] mult_p
);

  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MULT_LAT - 1);

  if (K + 1 > MULT_W || MULT_LAT < 1) begin : g_param_check
    $error("barrett_reduce_param: requires K+1 <= MULT_W and MULT_LAT >= 1");
  end

  barrett_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*K-1:0]   x_q, x_d;
  // Holds q3 during MUL2, then the low K+1 bits of q3*M for SUB0.
  logic [K:0]       prod_q, prod_d;
  logic [K:0]       r_q, r_d;
  logic [K:0]       csub_r;

  barrett_csub #(
    .K (K),
    .M (M)
  ) u_csub (
    .r_i (r_q),
    .r_o (csub_r)
  );

  if (2 * MULT_W > 2 * K + 2) begin : g_unused_prod
    logic unused_mult_p;
    assign unused_mult_p = ^mult_p[2*MULT_W-1:2*K+2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      prod_q  <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      prod_q  <= prod_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    prod_d    = prod_q;
    r_d       = r_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    mult_a    = '0;
    mult_b    = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_data;
          state_d = MUL1;
          cnt_d   = CNT_RELOAD;
`ifdef BARRETT_BYPASS_EN
          if (in_data < (2*K)'(M)) begin
            r_d     = (K+1)'(in_data);
            state_d = DONE;
            cnt_d   = '0;
          end
`endif
        end
      end

      MUL1: begin
        mult_a = MULT_W'(x_q[2*K-1:K-1]);
        mult_b = MULT_W'(MU);
        if (cnt_q == '0) begin
          prod_d  = mult_p[2*K+1:K+1];
          state_d = MUL2;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      MUL2: begin
        mult_a = MULT_W'(prod_q);
        mult_b = MULT_W'(M);
        if (cnt_q == '0) begin
          prod_d  = mult_p[K:0];
          state_d = SUB0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Wraps mod 2^(K+1); the true remainder is below 2^(K+1) so no information is lost.
      SUB0: begin
        r_d     = x_q[K:0] - prod_q;
        state_d = SUB1;
      end

      SUB1: begin
        r_d     = csub_r;
        state_d = SUB2;
      end

      SUB2: begin
        r_d     = csub_r;
        state_d = DONE;
      end

      DONE: begin
        out_valid = 1'b1;
        out_data  = r_q[K-1:0];
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_barrett_reduce_param.sv
// Directed and random checks of barrett_reduce_param at the Ed25519 defaults
// and at K=127, M=2^127-1, MULT_LAT=3, each with a behavioural pipelined multiplier.
module tb_barrett_reduce_param;

  localparam int KA = 253;
  localparam int WA = 256;
  localparam int LA = 10;
  localparam logic [KA-1:0] MA =
    253'h1000_0000_0000_0000_0000_0000_0000_0000_14de_f9de_a2f7_9cd6_5812_631a_5cf5_d3ed;

  localparam int KB = 127;
  localparam int WB = 128;
  localparam int LB = 3;
  localparam logic [KB-1:0] MB  = '1;
  localparam logic [KB:0]   MUB = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  localparam int LAT_A = 2 * LA + 4;
  localparam int LAT_B = 2 * LB + 4;
`ifdef BARRETT_BYPASS_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = LAT_A;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2*KA-1:0] in_data_a;
  logic            in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [KA-1:0]   out_data_a;
  logic [WA-1:0]   mult_a_a, mult_b_a;
  logic [2*WA-1:0] mult_p_a, prod_a;
  logic [2*WA-1:0] pipe_a [LA-1];

  logic [2*KB-1:0] in_data_b;
  logic            in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [KB-1:0]   out_data_b;
  logic [WB-1:0]   mult_a_b, mult_b_b;
  logic [2*WB-1:0] mult_p_b, prod_b;
  logic [2*WB-1:0] pipe_b [LB-1];

  barrett_reduce_param dut_a (
    .clk(clk), .rst(rst),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .mult_a(mult_a_a), .mult_b(mult_b_a), .mult_p(mult_p_a)
  );

  barrett_reduce_param #(
    .K(KB), .M(MB), .MU(MUB), .MULT_W(WB), .MULT_LAT(LB)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .mult_a(mult_a_b), .mult_b(mult_b_b), .mult_p(mult_p_b)
  );

  // Product appears MULT_LAT cycles after the operands first show up.
  assign prod_a   = (2*WA)'(mult_a_a) * (2*WA)'(mult_b_a);
  assign prod_b   = (2*WB)'(mult_a_b) * (2*WB)'(mult_b_b);
  assign mult_p_a = pipe_a[LA-2];
  assign mult_p_b = pipe_b[LB-2];

  always @(posedge clk) begin
    pipe_a[0] <= prod_a;
    for (int i = 1; i < LA - 1; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= prod_b;
    for (int i = 1; i < LB - 1; i++) pipe_b[i] <= pipe_b[i-1];
  end

  int checks = 0;
  int errors = 0;
  int zero_viol = 0;
  int bypass_mult_nz = 0;
  bit bypass_watch = 1'b0;

  always @(negedge clk) begin
    if (!rst && !out_valid_a && out_data_a != '0) zero_viol <= zero_viol + 1;
    if (!rst && !out_valid_b && out_data_b != '0) zero_viol <= zero_viol + 1;
    if (bypass_watch && (mult_a_a != '0 || mult_b_a != '0)) bypass_mult_nz <= bypass_mult_nz + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp,
                       input bit verbose);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else if (verbose) begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic op_a(input logic [2*KA-1:0] x, input int hold, output logic [KA-1:0] res,
                      output int lat, output bit stable, output bit idle_after);
    int guard;
    guard = 0;
    while (!in_ready_a && guard < 100) begin @(negedge clk); guard++; end
    in_data_a  = x;
    in_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    in_data_a  = '0;
    lat = 1;
    while (!out_valid_a && lat < 200) begin @(negedge clk); lat++; end
    res    = out_data_a;
    stable = out_valid_a;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid_a || out_data_a !== res || in_ready_a) stable = 1'b0;
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    out_ready_a = 1'b0;
    idle_after  = in_ready_a && !out_valid_a;
  endtask

  task automatic op_b(input logic [2*KB-1:0] x, output logic [KB-1:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready_b && guard < 100) begin @(negedge clk); guard++; end
    in_data_b  = x;
    in_valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_b = 1'b0;
    in_data_b  = '0;
    lat = 1;
    while (!out_valid_b && lat < 100) begin @(negedge clk); lat++; end
    res = out_data_b;
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
  endtask

  typedef struct {
    string           name;
    logic [2*KA-1:0] x;
    logic [KA-1:0]   exp;
    int              lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [2*KA-1:0] xmax, mm;
    logic [KA-1:0]   res;
    logic [KB-1:0]   res_b, exp_b;
    logic [2*KB-1:0] xb;
    int              lat;
    bit              stable, idle_after, seen;

    rst = 1'b1;
    in_data_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset in_ready_a", 512'(in_ready_a), 512'(1), 1'b1);
    check("reset out_valid_a", 512'(out_valid_a), 512'(0), 1'b1);
    check("reset out_data_a", 512'(out_data_a), 512'(0), 1'b1);
    check("reset mult_a_a", 512'(mult_a_a), 512'(0), 1'b1);
    check("reset mult_b_a", 512'(mult_b_a), 512'(0), 1'b1);
    check("reset in_ready_b", 512'(in_ready_b), 512'(1), 1'b1);

    xmax = '1;
    mm   = (2*KA)'(MA) * (2*KA)'(MA) - (2*KA)'(1);
    vecs[0] = '{name: "x=0",        x: '0,                              exp: '0,      lat: LAT_SMALL};
    vecs[1] = '{name: "x=M+5",      x: (2*KA)'(MA) + (2*KA)'(5),        exp: KA'(5),  lat: LAT_A};
    vecs[2] = '{name: "x=2M-1",     x: 2 * (2*KA)'(MA) - (2*KA)'(1),    exp: MA - 1,  lat: LAT_A};
    vecs[3] = '{name: "x=M*M-1",    x: mm,                              exp: MA - 1,  lat: LAT_A};
    vecs[4] = '{name: "x=2^506-1",  x: xmax, exp: KA'(xmax % (2*KA)'(MA)), lat: LAT_A};

    for (int i = 0; i < 5; i++) begin
      op_a(vecs[i].x, 0, res, lat, stable, idle_after);
      check({vecs[i].name, " result"}, 512'(res), 512'(vecs[i].exp), 1'b1);
      check({vecs[i].name, " latency"}, 512'(lat), 512'(vecs[i].lat), 1'b1);
    end

    // Backpressure: hold out_ready low for 7 cycles in DONE.
    op_a((2*KA)'(MA) + (2*KA)'(9), 7, res, lat, stable, idle_after);
    check("backpressure result", 512'(res), 512'(9), 1'b1);
    check("backpressure stable", 512'(stable), 512'(1), 1'b1);
    check("backpressure idle after release", 512'(idle_after), 512'(1), 1'b1);

    // Reset during MUL2 abandons the operation.
    in_data_a  = 3 * (2*KA)'(MA) + (2*KA)'(12345);
    in_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    in_data_a  = '0;
    repeat (LA + 2) @(negedge clk);
    check("abort in MUL2 mult_b", 512'(mult_b_a), 512'(MA), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort mult_a after reset", 512'(mult_a_a), 512'(0), 1'b1);
    check("abort in_ready after reset", 512'(in_ready_a), 512'(1), 1'b1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid_a) seen = 1'b1;
    end
    check("abort no out_valid", 512'(seen), 512'(0), 1'b1);
    op_a((2*KA)'(MA) + (2*KA)'(1), 0, res, lat, stable, idle_after);
    check("after abort x=M+1 result", 512'(res), 512'(1), 1'b1);
    check("after abort x=M+1 latency", 512'(lat), 512'(LAT_A), 1'b1);

    // Small operand and x=M boundary for the bypass path.
    bypass_watch = 1'b1;
    op_a((2*KA)'(7), 0, res, lat, stable, idle_after);
    bypass_watch = 1'b0;
    check("x=7 result", 512'(res), 512'(7), 1'b1);
    check("x=7 latency", 512'(lat), 512'(LAT_SMALL), 1'b1);
`ifdef BARRETT_BYPASS_EN
    check("x=7 multiplier idle", 512'(bypass_mult_nz), 512'(0), 1'b1);
`endif
    op_a((2*KA)'(MA), 0, res, lat, stable, idle_after);
    check("x=M result", 512'(res), 512'(0), 1'b1);
    check("x=M latency", 512'(lat), 512'(LAT_A), 1'b1);

    // K=127 instance against the % golden model.
    for (int n = 0; n < 1000; n++) begin
      xb    = (2*KB)'({$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()});
      exp_b = KB'(xb % (2*KB)'(MB));
      op_b(xb, res_b, lat);
      check("k127 result", 512'(res_b), 512'(exp_b), 1'b0);
      check("k127 latency", 512'(lat), 512'(LAT_B), 1'b0);
      $display("k127 #%0d x=%0h out=%0h lat=%0d", n, xb, res_b, lat);
    end

    check("out_data zero while out_valid low", 512'(zero_viol), 512'(0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
